mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller downstream of the load/store buffer and instruction fetch.
- Arbitrates word instruction fetches and LSB loads/stores onto the single 8-bit synchronous RAM/IO port.
- Assembles read bytes into 32-bit results (sign/zero extended for loads) and splits store data into bytes.
- Returns one done pulse per request to the requester.

Parameters:
- ADDR_WIDTH, 32, width of all address ports and mem_a.
- IO_ADDR_BASE, 32'h0003_0000, start of the memory-mapped IO region; an address is IO iff addr[17:16]==2'b11.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- clear  input  1  mispredict flush from ROB
- mem_din  input  8  RAM read byte, valid 1 cycle after its address
- mem_dout  output  8  RAM write byte
- mem_a  output  ADDR_WIDTH  RAM byte address
- mem_wr  output  1  1 = write, 0 = read
- io_buffer_full  input  1  IO output buffer full
- if_req  input  1  fetch request, held until if_done
- if_addr  input  ADDR_WIDTH  fetch address
- if_done  output  1  one-cycle fetch completion pulse
- if_data  output  32  fetched word, valid with if_done
- lsb_req  input  1  LSB request, held until lsb_done
- lsb_wr  input  1  1 = store, 0 = load
- lsb_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- lsb_signed  input  1  sign-extend load result
- lsb_addr  input  ADDR_WIDTH  access address (misalignment allowed)
- lsb_wdata  input  32  store data; low bytes are used
- lsb_done  output  1  one-cycle completion pulse
- lsb_rdata  output  32  load result, valid with lsb_done

Behaviour:
- Reset (rst_in high at a clock edge):
  - State goes to IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0.
  - Reset takes priority over rdy_in and clear, and aborts any access mid-operation.
- rdy_in low: no state, counter or output-register change. mem_wr is forced to 0 combinationally.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - clear high: no request is accepted.
  - Otherwise lsb_req has priority over if_req.
  - Latch addr, size, write data, signed flag and source. N = 1/2/4 bytes (fetch is always 4).
  - Go to READ or WRITE. Cycle of acceptance = c.
- READ:
  - Cycle c+1+k drives mem_a=addr+k, mem_wr=0, for k=0..N-1.
  - The byte is captured from mem_din at c+2+k into byte lane k.
  - Go to DONE after the last capture. The done pulse and data appear in cycle c+N+2.
  - Address arithmetic is modulo 2^ADDR_WIDTH (wraps).
- WRITE:
  - Cycle c+1+k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - DONE follows; lsb_done is asserted in cycle c+N+1.
- DONE:
  - Asserts the done pulse of the latched source for exactly one cycle, then returns to IDLE.
  - Requesters must drop req on the edge ending the done cycle; IDLE never re-accepts the just-finished request.
- Load result:
  - Bytes are assembled little-endian.
  - size 00: bits [31:8] = signed ? {24{b0[7]}} : 0.
  - size 01: bits [31:16] = signed ? {16{b1[7]}} : 0.
- clear while in READ:
  - A fetch or LSB load is aborted: return to IDLE next cycle with no done pulse.
  - Stores are already committed and are never aborted; a WRITE completes normally.
  - clear in DONE of a read suppresses the pulse.
- Outside WRITE cycles mem_wr=0. mem_a holds its last value, with no spurious writes.
- Simultaneous if_req and lsb_req in IDLE: LSB is served first, and fetch is accepted at the next IDLE.

Optional Feature:
- MEM_IO_STALL_EN defined:
  - Before each write byte whose address is in the IO region, the controller holds in WRITE while io_buffer_full is high.
  - During the hold, mem_wr=0 and the byte counter is unchanged.
  - Done is delayed by the number of stall cycles.
- Not defined: io_buffer_full is ignored and writes never stall.

Decomposition:
- Package mem_pkg holds:
  - size encodings (MEM_BYTE/HALF/WORD);
  - state enum;
  - source enum (SRC_IF, SRC_LSB);
  - IO_ADDR_BASE.
- One natural sub-module: mem_load_ext, combinational. It takes 4 captured bytes, size and signed, and produces the 32-bit load result.

Test Plan:
- RAM[0x100..0x103]=EF BE AD DE; if_req addr 0x100 accepted at cycle c -> if_done at c+6, if_data=0xDEADBEEF; mem_a = 0x100..0x103 in cycles c+1..c+4.
- LSB load byte signed, addr 0x200 holds 0x80 -> lsb_rdata=0xFFFFFF80. Unsigned -> 0x00000080. Half signed of 0x8001 -> 0xFFFF8001.
- LSB store word 0x11223344 at 0x300 -> mem_wr=1 with mem_dout 44,33,22,11 at 0x300..0x303; lsb_done at c+5; read-back returns 0x11223344.
- if_req and lsb_req both high in IDLE -> LSB served first, fetch accepted immediately after LSB DONE; clear during fetch READ -> no if_done, IDLE next cycle; clear during store -> store completes.
- rdy_in low for 3 cycles mid-read -> mem_wr=0 and state frozen, done delayed exactly 3 cycles; rst_in mid-write -> all outputs 0 next cycle.
- With MEM_IO_STALL_EN: store byte to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays 0, write issues when the flag drops, lsb_done delayed 5 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory controller.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [31:0] IO_ADDR_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
    typedef enum logic {SRC_IF, SRC_LSB} src_e;

    // Encoding 2'b11 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_BYTE: size_bytes = 3'd1;
            MEM_HALF: size_bytes = 3'd2;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port bundle; slave = controller side, master = fetch/LSB/RAM side.
interface mem_ctrl_if #(parameter int ADDR_WIDTH = 32);

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;

    logic                  lsb_req;
    logic                  lsb_wr;
    logic [1:0]            lsb_size;
    logic                  lsb_signed;
    logic [ADDR_WIDTH-1:0] lsb_addr;
    logic [31:0]           lsb_wdata;
    logic                  lsb_done;
    logic [31:0]           lsb_rdata;

    modport slave (
        input  mem_din, if_req, if_addr,
        input  lsb_req, lsb_wr, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
        output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
    );

    modport master (
        output mem_din, if_req, if_addr,
        output lsb_req, lsb_wr, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
        input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load result formatter: little-endian bytes, sign/zero extended by size.
// Latency: combinational. Backpressure: none.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [3:0][7:0] bytes,
    input  logic [1:0]      size,
    input  logic            is_signed,
    output logic [31:0]     result
);

    always_comb begin
        result = bytes;
        case (size)
            MEM_BYTE: result[31:8]  = is_signed ? {24{bytes[0][7]}} : 24'd0;
            MEM_HALF: result[31:16] = is_signed ? {16{bytes[1][7]}} : 16'd0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller arbitrating LSB (priority) and fetch onto one 8-bit port.
// Latency: read done at accept+N+2, write done at accept+N+1 (N = 1/2/4 bytes).
// Backpressure: rdy_in low freezes everything; MEM_IO_STALL_EN holds IO writes while io_buffer_full.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clear,
    input  logic       io_buffer_full,
    mem_ctrl_if.slave  bus
);

    state_e                state;
    src_e                  src_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [3:0][7:0]       wdata_q;
    logic [2:0]            n_q;
    logic [2:0]            cnt;
    logic [3:0][7:0]       bytes_q;
    logic [3:0][7:0]       bytes_nxt;
    logic [31:0]           ext_data;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  if_done_q;
    logic                  lsb_done_q;
    logic [31:0]           if_data_q;
    logic [31:0]           lsb_rdata_q;
    logic                  stall;

`ifdef MEM_IO_STALL_EN
    assign stall = io_buffer_full && (mem_a_q[17:16] == IO_ADDR_BASE[17:16]);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign stall          = 1'b0;
`endif

    // Byte k arrives while cnt == k+1; merge it so the final lane is in the result.
    always_comb begin
        bytes_nxt = bytes_q;
        if (cnt != 3'd0)
            bytes_nxt[cnt[1:0] - 2'd1] = bus.mem_din;
    end

    mem_load_ext u_ext (
        .bytes     (bytes_nxt),
        .size      (size_q),
        .is_signed (sign_q),
        .result    (ext_data)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            src_q       <= SRC_IF;
            wr_q        <= 1'b0;
            size_q      <= MEM_WORD;
            sign_q      <= 1'b0;
            wdata_q     <= '0;
            n_q         <= 3'd0;
            cnt         <= 3'd0;
            bytes_q     <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear && (bus.lsb_req || bus.if_req)) begin
                        cnt     <= 3'd0;
                        bytes_q <= '0;
                        if (bus.lsb_req) begin
                            src_q      <= SRC_LSB;
                            wr_q       <= bus.lsb_wr;
                            size_q     <= bus.lsb_size;
                            sign_q     <= bus.lsb_signed;
                            wdata_q    <= bus.lsb_wdata;
                            n_q        <= size_bytes(bus.lsb_size);
                            mem_a_q    <= bus.lsb_addr;
                            mem_dout_q <= bus.lsb_wdata[7:0];
                            mem_wr_q   <= bus.lsb_wr;
                            state      <= bus.lsb_wr ? WRITE : READ;
                        end else begin
                            src_q   <= SRC_IF;
                            wr_q    <= 1'b0;
                            size_q  <= MEM_WORD;
                            sign_q  <= 1'b0;
                            n_q     <= 3'd4;
                            mem_a_q <= bus.if_addr;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (clear) begin
                        state <= IDLE;
                    end else begin
                        bytes_q <= bytes_nxt;
                        cnt     <= cnt + 3'd1;
                        if (cnt + 3'd1 < n_q)
                            mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                        if (cnt == n_q) begin
                            state <= DONE;
                            if (src_q == SRC_IF) begin
                                if_done_q <= 1'b1;
                                if_data_q <= ext_data;
                            end else begin
                                lsb_done_q  <= 1'b1;
                                lsb_rdata_q <= ext_data;
                            end
                        end
                    end
                end
                WRITE: begin
                    // Stores are committed: clear is deliberately ignored here.
                    if (!stall) begin
                        if (cnt + 3'd1 == n_q) begin
                            mem_wr_q   <= 1'b0;
                            lsb_done_q <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
                            mem_dout_q <= wdata_q[cnt[1:0] + 2'd1];
                            cnt        <= cnt + 3'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.mem_wr    = mem_wr_q & rdy_in & ~stall;
    assign bus.if_data   = if_data_q;
    assign bus.lsb_rdata = lsb_rdata_q;
    // A flush arriving in the done cycle of a read still kills the pulse.
    assign bus.if_done   = if_done_q & ~clear;
    assign bus.lsb_done  = lsb_done_q & ~(clear & ~wr_q);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed corner cases plus random fetch/load/store traffic.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clear = 1'b0;
    logic io_full = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .clear          (clear),
        .io_buffer_full (io_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    logic [7:0] mdl [0:65535];

    // Environment RAM: one-cycle read latency, paused along with the core.
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[15:0]];
        end
    end

    typedef struct { logic [31:0] data; bit chk_data; int cyc; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t ifq[$];
    exp_t lsbq[$];
    wr_t  wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Reference model: plain byte arithmetic over the shadow memory.
    task automatic push_exp(input bit is_if, input bit wr, input logic [1:0] size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wdata, input int when);
        int n;
        logic [31:0] a;
        logic [31:0] val;
        exp_t e;
        n = nbytes(is_if, size);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                a = addr + k;
                wq.push_back('{a, 8'((wdata >> (8 * k)) & 32'hFF)});
                mdl[a[15:0]] = 8'((wdata >> (8 * k)) & 32'hFF);
            end
            e = '{32'd0, 1'b0, when};
            lsbq.push_back(e);
        end else begin
            val = 0;
            for (int k = 0; k < n; k++) begin
                a = addr + k;
                val = val + (32'(mdl[a[15:0]]) << (8 * k));
            end
            if (!is_if && sgn && n == 1 && val >= 128) val = val + 32'hFFFF_FF00;
            if (!is_if && sgn && n == 2 && val >= 32768) val = val + 32'hFFFF_0000;
            e = '{val, 1'b1, when};
            if (is_if) ifq.push_back(e);
            else lsbq.push_back(e);
        end
    endtask

    task automatic drive(input bit is_if, input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.lsb_req    = 1'b1;
            bus.lsb_wr     = wr;
            bus.lsb_size   = size;
            bus.lsb_signed = sgn;
            bus.lsb_addr   = addr;
            bus.lsb_wdata  = wdata;
        end
    endtask

    task automatic wait_done(input bit is_if);
        bit seen = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (rdy && (is_if ? bus.if_done : bus.lsb_done)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout act=none exp=pulse src_if=%0d", is_if);
        end
        @(posedge clk); #1;
        if (is_if) bus.if_req = 1'b0;
        else bus.lsb_req = 1'b0;
    endtask

    task automatic run_op(input bit is_if, input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int extra);
        int lat;
        lat = nbytes(is_if, size) + (wr ? 1 : 2) + extra;
        push_exp(is_if, wr, size, sgn, addr, wdata, cyc + lat);
        drive(is_if, wr, size, sgn, addr, wdata);
        wait_done(is_if);
    endtask

    // Monitor: every done pulse and every byte write is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rdy) begin
            if (bus.if_done === 1'b1) begin
                if (ifq.size() == 0) chk("if_unexpected", 1, 0);
                else begin
                    e = ifq.pop_front();
                    chk("if_cycle", cyc, e.cyc);
                    chk("if_data", bus.if_data, e.data);
                end
            end
            if (bus.lsb_done === 1'b1) begin
                if (lsbq.size() == 0) chk("lsb_unexpected", 1, 0);
                else begin
                    e = lsbq.pop_front();
                    chk("lsb_cycle", cyc, e.cyc);
                    if (e.chk_data) chk("lsb_rdata", bus.lsb_rdata, e.data);
                end
            end
            if (bus.mem_wr === 1'b1) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", bus.mem_a, w.a);
                    chk("wr_data", 32'(bus.mem_dout), 32'(w.d));
                end
            end
        end
    end

    initial begin
        int p;
        int io_extra;
        logic [31:0] r;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = 2'b00;
        bus.lsb_signed = 1'b0; bus.lsb_addr = '0; bus.lsb_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            r = $urandom;
            ram[i] = r[7:0];
            mdl[i] = r[7:0];
        end
        ram[16'h100] = 8'hEF; ram[16'h101] = 8'hBE; ram[16'h102] = 8'hAD; ram[16'h103] = 8'hDE;
        mdl[16'h100] = 8'hEF; mdl[16'h101] = 8'hBE; mdl[16'h102] = 8'hAD; mdl[16'h103] = 8'hDE;
        ram[16'h200] = 8'h80; mdl[16'h200] = 8'h80;
        ram[16'h210] = 8'h01; mdl[16'h210] = 8'h01;
        ram[16'h211] = 8'h80; mdl[16'h211] = 8'h80;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_if_done", 32'(bus.if_done), 0);
        chk("rst_lsb_done", 32'(bus.lsb_done), 0);
        chk("rst_if_data", bus.if_data, 0);
        chk("rst_lsb_rdata", bus.lsb_rdata, 0);
        @(posedge clk); #1;

        // Fetch of DEADBEEF with the address walk checked cycle by cycle.
        push_exp(1, 0, 2'b10, 0, 32'h100, 0, cyc + 6);
        chk("model_fetch", ifq[0].data, 32'hDEAD_BEEF);
        drive(1, 0, 2'b10, 0, 32'h100, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("fetch_mem_a", bus.mem_a, 32'h100 + k);
        end
        wait_done(1);

        run_op(0, 0, 2'b00, 1, 32'h200, 0, 0);
        run_op(0, 0, 2'b00, 0, 32'h200, 0, 0);
        run_op(0, 0, 2'b01, 1, 32'h210, 0, 0);
        run_op(0, 1, 2'b10, 0, 32'h300, 32'h1122_3344, 0);
        run_op(0, 0, 2'b10, 0, 32'h300, 0, 0);
        chk("model_store_rb", mdl[16'h302], 8'h22);

        // Both requests at once: LSB first, fetch taken in the cycle after LSB DONE.
        p = cyc;
        push_exp(0, 0, 2'b10, 0, 32'h104, 0, p + 6);
        push_exp(1, 0, 2'b10, 0, 32'h100, 0, p + 13);
        drive(0, 0, 2'b10, 0, 32'h104, 0);
        drive(1, 0, 2'b10, 0, 32'h100, 0);
        fork
            wait_done(0);
            wait_done(1);
        join

        // Flush mid-fetch: no pulse, and the next request sees an idle controller.
        drive(1, 0, 2'b10, 0, 32'h120, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 clear = 1'b1; bus.if_req = 1'b0;
        @(posedge clk); #1 clear = 1'b0;
        run_op(0, 0, 2'b10, 0, 32'h100, 0, 0);

        // Flush mid-store is ignored.
        fork
            run_op(0, 1, 2'b10, 0, 32'h320, 32'hCAFE_F00D, 0);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1 clear = 1'b1;
                @(posedge clk); #1 clear = 1'b0;
            end
        join

        // Flush in the DONE cycle of a load suppresses its pulse.
        drive(0, 0, 2'b00, 0, 32'h200, 0);
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        chk("clr_done_pulse", 32'(bus.lsb_done), 0);
        @(posedge clk); #1 clear = 1'b0; bus.lsb_req = 1'b0;

        // rdy_in low for 3 cycles mid-read and mid-write.
        push_exp(1, 0, 2'b10, 0, 32'h100, 0, cyc + 9);
        drive(1, 0, 2'b10, 0, 32'h100, 0);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        wait_done(1);

        push_exp(0, 1, 2'b10, 0, 32'h330, 32'h5566_7788, cyc + 8);
        drive(0, 1, 2'b10, 0, 32'h330, 32'h5566_7788);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frozen_mem_wr", 32'(bus.mem_wr), 0);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        wait_done(0);
        run_op(0, 0, 2'b10, 0, 32'h330, 0, 0);

        // Reset mid-write: bytes 0 and 1 land, then everything clears.
        wq.push_back('{32'h340, 8'hD8}); mdl[16'h340] = 8'hD8;
        wq.push_back('{32'h341, 8'hC7}); mdl[16'h341] = 8'hC7;
        drive(0, 1, 2'b10, 0, 32'h340, 32'hA5B6_C7D8);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; bus.lsb_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_mem_a", bus.mem_a, 0);
        chk("mrst_mem_dout", 32'(bus.mem_dout), 0);
        chk("mrst_mem_wr", 32'(bus.mem_wr), 0);
        chk("mrst_if_data", bus.if_data, 0);
        chk("mrst_lsb_rdata", bus.lsb_rdata, 0);
        chk("mrst_lsb_done", 32'(bus.lsb_done), 0);
        @(posedge clk); #1;
        run_op(0, 0, 2'b10, 0, 32'h340, 0, 0);

        // IO store while the IO buffer reports full for 5 write cycles.
`ifdef MEM_IO_STALL_EN
        io_extra = 5;
`else
        io_extra = 0;
`endif
        fork
            run_op(0, 1, 2'b00, 0, 32'h0003_0000, 32'h0000_005A, io_extra);
            begin
                io_full = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                chk("io_first_wr", 32'(bus.mem_wr), (io_extra == 0) ? 32'd1 : 32'd0);
                repeat (5) @(posedge clk);
                #1 io_full = 1'b0;
            end
        join

        // Address wrap at the top of the space, size 11 read as a word.
        run_op(0, 0, 2'b10, 1, 32'hFFFF_FFFE, 0, 0);
        run_op(0, 0, 2'b11, 1, 32'h0000_0101, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a = $urandom_range(0, 32'h3FF);
            if (op == 0) run_op(1, 0, 2'b10, 0, a, 0, 0);
            else run_op(0, op == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        chk("left_if", ifq.size(), 0);
        chk("left_lsb", lsbq.size(), 0);
        chk("left_wr", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
